// File: rtl/output_pulse_stretcher_pkg.sv
// ---------------------------------------------------------------------------
// output_pulse_stretcher_pkg
// Shared definitions for the output pulse stretcher:
//   - state_t : per-channel FSM encoding (IDLE / HOLD / GAP)
//   - default timing constants for a 50MHz clock and a 25us timebase
// ---------------------------------------------------------------------------
package output_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int TICK_DIV_25US_50MHZ = 1250;  // 1250 x 20ns = 25us
    localparam int HOLD_100MS          = 4000;  // 4000 x 25us = 100ms
    localparam int GAP_10MS            = 400;   //  400 x 25us = 10ms

endpackage

// File: rtl/output_pulse_stretcher_channel.sv
// ---------------------------------------------------------------------------
// output_pulse_stretcher_channel
// One stretcher channel: FSM, tick down-counter and pending bit.
// Turns a single-cycle event into a pulse with a minimum high time, followed
// by a minimum low gap. Both times are counted in timebase ticks.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   in   one-cycle timebase strobe shared by all channels
//   evt    in   event strobe (level high = event, sampled every posedge)
//   pulse  out  stretched output, registered
//   busy   out  high while not IDLE, registered
//
// Optional feature macro: OUTPUT_PULSE_STRETCHER_RETRIGGER_EN
//   defined   : an event during HOLD reloads the hold counter
//   undefined : events during HOLD are ignored
//
// State | meaning
// IDLE  | output low, waiting for an event
// HOLD  | output high, counting HOLD_TICKS down
// GAP   | output low, counting GAP_TICKS down, remembering events as pending
// ---------------------------------------------------------------------------
module output_pulse_stretcher_channel
    import output_pulse_stretcher_pkg::*;
#(
    parameter int HOLD_TICKS = HOLD_100MS,
    parameter int GAP_TICKS  = GAP_10MS,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic evt,
    output logic pulse,
    output logic busy
);

`ifdef OUTPUT_PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIGGER = 1'b1;
`else
    localparam bit RETRIGGER = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             pulse_q, busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            // Outputs follow the next state so they are registered with
            // one clock of latency from the event.
            pulse_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (evt) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            HOLD: begin
                // A retrigger reload wins over a tick in the same cycle, so a
                // steady event stream never lets the counter expire.
                if (RETRIGGER && evt) begin
                    cnt_d = HOLD_LD;
                end else if (tick) begin
                    if (cnt_q == CNT_ONE) begin
                        if (GAP_TICKS == 0) begin
                            if (pend_q) begin
                                cnt_d  = HOLD_LD;
                                pend_d = 1'b0;
                            end else begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end
                        end else begin
                            state_d = GAP;
                            cnt_d   = GAP_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            GAP: begin
                if (evt) begin
                    pend_d = 1'b1;
                end
                if (tick) begin
                    if (cnt_q == CNT_ONE) begin
                        // An event on the gap-ending tick counts as pending.
                        if (pend_q || evt) begin
                            state_d = HOLD;
                            cnt_d   = HOLD_LD;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                        pend_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;

endmodule

// File: rtl/output_pulse_stretcher_50mhz_25us.sv
// ---------------------------------------------------------------------------
// output_pulse_stretcher_50mhz_25us
// Stretches single-cycle status strobes into human-visible, glitch-free
// pulses for LED/indicator pads. A free-running prescaler produces a 25us
// tick (at 50MHz) shared by N independent stretcher channels.
//
// Ports:
//   iCLOCK   in   [1]    50MHz system clock
//   inRESET  in   [1]    asynchronous active-low reset
//   iEVENT   in   [N]    per-channel event strobes
//   oDATA    out  [N]    stretched pulses, registered
//   oBUSY    out  [N]    per-channel busy (HOLD or GAP), registered
//
// Optional feature macro: OUTPUT_PULSE_STRETCHER_RETRIGGER_EN
//   (retrigger during HOLD; handled inside output_pulse_stretcher_channel)
// ---------------------------------------------------------------------------
module output_pulse_stretcher_50mhz_25us
    import output_pulse_stretcher_pkg::*;
#(
    parameter int N          = 1,
    parameter int TICK_DIV   = TICK_DIV_25US_50MHZ,
    parameter int PRE_W      = 11,
    parameter int HOLD_TICKS = HOLD_100MS,
    parameter int GAP_TICKS  = GAP_10MS,
    parameter int CNT_W      = 16
) (
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic [N-1:0] iEVENT,
    output logic [N-1:0] oDATA,
    output logic [N-1:0] oBUSY
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] pre_q;
    logic             tick;

    // Tick is decoded straight from the prescaler so it is low in reset
    // and high for exactly the one cycle where the prescaler sits at its end.
    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_ONE;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        output_pulse_stretcher_channel #(
            .HOLD_TICKS (HOLD_TICKS),
            .GAP_TICKS  (GAP_TICKS),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk   (iCLOCK),
            .rst_n (inRESET),
            .tick  (tick),
            .evt   (iEVENT[g]),
            .pulse (oDATA[g]),
            .busy  (oBUSY[g])
        );
    end

endmodule

// File: tb/tb_output_pulse_stretcher_50mhz_25us.sv
// ---------------------------------------------------------------------------
// Testbench for output_pulse_stretcher_50mhz_25us.
// dut  : N=4, TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2
// dut0 : N=1, TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=0
// Relative cycle r counts samples after the posedge E that takes the first
// event; E is aligned so that timebase ticks are taken at r = 3, 7, 11, ...
// ---------------------------------------------------------------------------
module tb_output_pulse_stretcher_50mhz_25us;

`ifdef OUTPUT_PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ev;
    logic [3:0] data, busy;
    logic       ev0;
    logic       data0, busy0;

    int errors = 0;
    int checks = 0;
    int cyc;

    always #10 clk = ~clk;

    output_pulse_stretcher_50mhz_25us #(
        .N(4), .TICK_DIV(4), .PRE_W(2), .HOLD_TICKS(3), .GAP_TICKS(2), .CNT_W(4)
    ) dut (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .iEVENT  (ev),
        .oDATA   (data),
        .oBUSY   (busy)
    );

    output_pulse_stretcher_50mhz_25us #(
        .N(1), .TICK_DIV(4), .PRE_W(2), .HOLD_TICKS(3), .GAP_TICKS(0), .CNT_W(4)
    ) dut0 (
        .iCLOCK  (clk),
        .inRESET (rst_n),
        .iEVENT  (ev0),
        .oDATA   (data0),
        .oBUSY   (busy0)
    );

    // Posedges since reset release; cyc mod 4 gives the timebase phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align();
        for (int i = 0; i < 8 && (cyc % 4) != 0; i++) step();
        checks++;
        if ((cyc % 4) !== 0) begin
            errors++;
            $display("FAIL align cyc=%0d required phase 0", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ev    = 4'b0000;
        ev0   = 1'b0;
        repeat (5) step();
        checks++;
        if ({data, busy, data0, busy0} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state data=%b busy=%b data0=%b busy0=%b required all 0",
                     data, busy, data0, busy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step();
            checks++;
            if ({data, busy, data0, busy0} !== 10'b0) begin
                errors++;
                $display("FAIL idle cycle=%0d data=%b busy=%b data0=%b busy0=%b required all 0",
                         i, data, busy, data0, busy0);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] exp_d, exp_b;
        align();
        for (int r = 0; r <= 22; r++) begin
            ev = (r == 0) ? 4'b0001 : 4'b0000;
            step();
            exp_d = {3'b000, r <= 10};
            exp_b = {3'b000, r <= 18};
            checks++;
            if (data !== exp_d || busy !== exp_b) begin
                errors++;
                $display("FAIL basic r=%0d data=%b busy=%b required data=%b busy=%b",
                         r, data, busy, exp_d, exp_b);
            end
        end
        ev = 4'b0000;
    endtask

    task automatic test_pending();
        logic e;
        logic exp_d, exp_b;
        for (int p = 0; p < 3; p++) begin
            align();
            for (int r = 0; r <= 42; r++) begin
                case (p)
                    0:       e = (r == 0) || (r == 13);
                    1:       e = (r == 0) || (r == 12) || (r == 14) || (r == 16);
                    default: e = (r == 0) || (r == 19);
                endcase
                ev = {3'b000, e};
                step();
                exp_d = (r <= 10) || (r >= 19 && r <= 30);
                exp_b = (r <= 38);
                checks++;
                if (data !== {3'b000, exp_d} || busy !== {3'b000, exp_b}) begin
                    errors++;
                    $display("FAIL pending p=%0d r=%0d data=%b busy=%b required data=%b busy=%b",
                             p, r, data, busy, exp_d, exp_b);
                end
            end
            ev = 4'b0000;
        end
    endtask

    task automatic test_retrigger();
        logic exp_d, exp_b, fixed_d;
        align();
        for (int r = 0; r <= 82; r++) begin
            ev = {3'b000, (r <= 54) && (r % 6 == 0)};
            step();
            fixed_d = (r <= 10) || (r >= 19 && r <= 30) ||
                      (r >= 39 && r <= 50) || (r >= 59 && r <= 70);
            exp_d = RETRIG ? (r <= 62) : fixed_d;
            exp_b = RETRIG ? (r <= 70) : (r <= 78);
            checks++;
            if (data !== {3'b000, exp_d} || busy !== {3'b000, exp_b}) begin
                errors++;
                $display("FAIL retrigger r=%0d data=%b busy=%b required data=%b busy=%b",
                         r, data, busy, exp_d, exp_b);
            end
        end
        ev = 4'b0000;
    endtask

    task automatic test_gap_zero();
        logic exp_d;
        align();
        for (int r = 0; r <= 26; r++) begin
            ev0 = (r == 0) || (r == 11) || (r == 12);
            step();
            exp_d = RETRIG ? (r <= 22) : ((r <= 10) || (r >= 12 && r <= 22));
            checks++;
            if (data0 !== exp_d || busy0 !== exp_d) begin
                errors++;
                $display("FAIL gap_zero r=%0d data=%b busy=%b required data=%b busy=%b",
                         r, data0, busy0, exp_d, exp_d);
            end
        end
        ev0 = 1'b0;
    endtask

    task automatic test_multichannel_reset();
        logic [3:0] exp_d, exp_b;
        align();
        for (int r = 0; r <= 5; r++) begin
            ev = (r == 0) ? 4'b1001 : 4'b0000;
            step();
            checks++;
            if (data !== 4'b1001 || busy !== 4'b1001) begin
                errors++;
                $display("FAIL multi_hold r=%0d data=%b busy=%b required 1001/1001",
                         r, data, busy);
            end
        end
        ev = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data !== 4'b0000 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset data=%b busy=%b required 0000/0000", data, busy);
        end
        repeat (3) step();
        checks++;
        if (data !== 4'b0000 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held data=%b busy=%b required 0000/0000", data, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        align();
        for (int r = 0; r <= 22; r++) begin
            ev = (r == 0) ? 4'b0001 : 4'b0000;
            step();
            exp_d = {3'b000, r <= 10};
            exp_b = {3'b000, r <= 18};
            checks++;
            if (data !== exp_d || busy !== exp_b) begin
                errors++;
                $display("FAIL after_reset r=%0d data=%b busy=%b required data=%b busy=%b",
                         r, data, busy, exp_d, exp_b);
            end
        end
        ev = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pending();
        test_retrigger();
        test_gap_zero();
        test_multichannel_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
